inst_fetch_bridge: RTL and testbench

Instruction-side responder for the fetch-address generator. Accepts the fetch address and chip-enable produced by the PC stage, issues a single-outstanding read on an SRAM-like instruction bus (req/addr_ok/data_ok), and returns the instruction word to the IF/ID boundary. While a fetch is in flight it raises a stall request to the pipeline control module. It also discards in-flight fetches on exception flush.

---
 rtl/inst_fetch_bridge.sv | 169 ++++++++++++++++
 tb/tb_inst_fetch_bridge.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_bridge.sv
// rtl/inst_fetch_bridge.sv - single-outstanding instruction fetch bridge to an SRAM-like bus
// Optional kseg0/kseg1 address translation: define INST_FETCH_ADDR_MAP_EN.
module inst_fetch_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              stallreq_o,
    output logic [DATA_W-1:0] inst_o,
    output logic              inst_valid_o,
    output logic              adel_o,
    output logic              req_o,
    output logic [ADDR_W-1:0] addr_o,
    input  logic              addr_ok_i,
    input  logic              data_ok_i,
    input  logic [DATA_W-1:0] rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_cnl;
    logic              w_cnl_nxt;
    logic              r_req;
    logic              w_req_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] r_inst;
    logic [DATA_W-1:0] w_inst_nxt;
    logic              r_inst_valid;
    logic              w_inst_valid_nxt;
    logic              r_adel;
    logic              w_adel_nxt;

    logic              w_fetch;
    logic              w_aligned;
    logic [ADDR_W-1:0] w_map_addr;

    assign w_fetch   = ce_i & ~flush_i;
    assign w_aligned = (pc_i[1:0] == 2'b00);

`ifdef INST_FETCH_ADDR_MAP_EN
    // kseg0/kseg1 both alias the low 512 MB of physical space
    assign w_map_addr = (pc_i[ADDR_W-1:ADDR_W-2] == 2'b10) ? {3'b000, pc_i[ADDR_W-4:0]} : pc_i;
`else
    assign w_map_addr = pc_i;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnl        <= 1'b0;
            r_req        <= 1'b0;
            r_addr       <= '0;
            r_inst       <= '0;
            r_inst_valid <= 1'b0;
            r_adel       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnl        <= w_cnl_nxt;
            r_req        <= w_req_nxt;
            r_addr       <= w_addr_nxt;
            r_inst       <= w_inst_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            r_adel       <= w_adel_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_fetch) begin
                    w_state_nxt = w_aligned ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                if (addr_ok_i) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // a flush arriving with the data cancels it just like an earlier flush
                if (data_ok_i) begin
                    w_state_nxt = (r_cnl | flush_i) ? S_IDLE : S_DONE;
                end
            end
            S_DONE: begin
                if (flush_i | ~stall_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_cnl_nxt        = r_cnl;
        w_req_nxt        = r_req;
        w_addr_nxt       = r_addr;
        w_inst_nxt       = r_inst;
        w_inst_valid_nxt = r_inst_valid;
        w_adel_nxt       = r_adel;
        case (r_state)
            S_IDLE: begin
                if (w_fetch) begin
                    if (w_aligned) begin
                        w_req_nxt  = 1'b1;
                        w_addr_nxt = w_map_addr;
                    end else begin
                        w_inst_nxt       = '0;
                        w_inst_valid_nxt = 1'b1;
                        w_adel_nxt       = 1'b1;
                    end
                end
            end
            S_REQ: begin
                // the request stays up until accepted; a flush only marks it for discard
                if (flush_i) begin
                    w_cnl_nxt = 1'b1;
                end
                if (addr_ok_i) begin
                    w_req_nxt = 1'b0;
                end
            end
            S_WAIT: begin
                if (data_ok_i) begin
                    if (r_cnl | flush_i) begin
                        w_cnl_nxt = 1'b0;
                    end else begin
                        w_inst_nxt       = rdata_i;
                        w_inst_valid_nxt = 1'b1;
                    end
                end else if (flush_i) begin
                    w_cnl_nxt = 1'b1;
                end
            end
            S_DONE: begin
                if (flush_i | ~stall_i) begin
                    w_inst_valid_nxt = 1'b0;
                    w_adel_nxt       = 1'b0;
                end
            end
            default: begin
                w_cnl_nxt = 1'b0;
            end
        endcase
    end

    assign stallreq_o   = ~rst & (((r_state == S_IDLE) & w_fetch) |
                                  (r_state == S_REQ) | (r_state == S_WAIT));
    assign req_o        = r_req;
    assign addr_o       = r_addr;
    assign inst_o       = r_inst;
    assign inst_valid_o = r_inst_valid;
    assign adel_o       = r_adel;

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// tb/tb_inst_fetch_bridge.sv - directed and randomized bench for inst_fetch_bridge
// Expected bus address follows INST_FETCH_ADDR_MAP_EN when defined.
module tb_inst_fetch_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        ce_i;
    logic        stall_i;
    logic        flush_i;
    logic        stallreq_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        adel_o;
    logic        req_o;
    logic [31:0] addr_o;
    logic        addr_ok_i;
    logic        data_ok_i;
    logic [31:0] rdata_i;

    int n_cmp  = 0;
    int n_fail = 0;

    inst_fetch_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .ce_i         (ce_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .stallreq_o   (stallreq_o),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .adel_o       (adel_o),
        .req_o        (req_o),
        .addr_o       (addr_o),
        .addr_ok_i    (addr_ok_i),
        .data_ok_i    (data_ok_i),
        .rdata_i      (rdata_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_addr(input logic [31:0] pc);
`ifdef INST_FETCH_ADDR_MAP_EN
        return (pc[31:30] == 2'b10) ? (pc & 32'h1fff_ffff) : pc;
`else
        return pc;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // One aligned fetch: a = REQ cycles before addr_ok, d = WAIT cycles up to data_ok (>=1),
    // hold = DONE cycles with stall_i high; last DONE cycle optionally flushed.
    task automatic fetch(input logic [31:0] pc, input int a, input int d,
                         input logic [31:0] data, input int hold, input bit flush_done);
        ce_i = 1'b1; pc_i = pc; stall_i = 1'b0; flush_i = 1'b0;
        addr_ok_i = 1'($urandom); data_ok_i = 1'($urandom); rdata_i = $urandom;
        #1;
        chk("idle_stallreq", stallreq_o, 1);
        chk("idle_req", req_o, 0);
        chk("idle_valid", inst_valid_o, 0);
        adv();
        for (int i = 0; i <= a; i++) begin
            addr_ok_i = (i == a); data_ok_i = 1'($urandom); rdata_i = $urandom;
            #1;
            chk("req_hi", req_o, 1);
            chk("req_addr", addr_o, exp_addr(pc));
            chk("req_stallreq", stallreq_o, 1);
            chk("req_valid", inst_valid_o, 0);
            adv();
        end
        for (int i = 1; i <= d; i++) begin
            addr_ok_i = 1'($urandom); data_ok_i = (i == d);
            rdata_i = (i == d) ? data : $urandom;
            #1;
            chk("wait_req", req_o, 0);
            chk("wait_stallreq", stallreq_o, 1);
            chk("wait_valid", inst_valid_o, 0);
            adv();
        end
        for (int i = 0; i <= hold; i++) begin
            stall_i = (i < hold) || flush_done;
            flush_i = (i == hold) && flush_done;
            addr_ok_i = 1'($urandom); data_ok_i = 1'($urandom); rdata_i = $urandom;
            #1;
            chk("done_valid", inst_valid_o, 1);
            chk("done_inst", inst_o, data);
            chk("done_adel", adel_o, 0);
            chk("done_req", req_o, 0);
            chk("done_stallreq", stallreq_o, 0);
            adv();
        end
        stall_i = 1'b0; flush_i = 1'b0;
    endtask

    initial begin
        logic [31:0] pc;
        rst = 1'b1; ce_i = 1'b1; pc_i = 32'hbfc0_0000; stall_i = 1'b0; flush_i = 1'b0;
        addr_ok_i = 1'b0; data_ok_i = 1'b0; rdata_i = '0;
        adv(); adv(); adv();
        chk("rst_stallreq", stallreq_o, 0);
        chk("rst_req", req_o, 0);
        chk("rst_addr", addr_o, 0);
        chk("rst_inst", inst_o, 0);
        chk("rst_valid", inst_valid_o, 0);
        chk("rst_adel", adel_o, 0);
        rst = 1'b0;

        // minimum-latency boot fetch, then slow bus, then stalled DONE and pc+4
        fetch(32'hbfc0_0000, 0, 1, 32'h3c01_0001, 0, 1'b0);
        fetch(32'hbfc0_0004, 3, 2, 32'h2402_0005, 0, 1'b0);
        fetch(32'hbfc0_0008, 1, 1, 32'h8c43_0000, 4, 1'b0);
        fetch(32'hbfc0_000c, 0, 2, 32'h1000_ffff, 0, 1'b0);

        // flush during REQ with late addr_ok: data discarded
        ce_i = 1'b1; pc_i = 32'hbfc0_0010; addr_ok_i = 1'b0; data_ok_i = 1'b0;
        #1; chk("fr_idle_stallreq", stallreq_o, 1);
        adv();
        flush_i = 1'b1;
        #1; chk("fr_req_flush", req_o, 1);
        adv();
        flush_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            addr_ok_i = (i == 1);
            #1;
            chk("fr_req_held", req_o, 1);
            chk("fr_stallreq", stallreq_o, 1);
            adv();
        end
        addr_ok_i = 1'b0; data_ok_i = 1'b1; rdata_i = 32'hdead_beef;
        #1; chk("fr_wait_req", req_o, 0);
        adv();
        data_ok_i = 1'b0; ce_i = 1'b0;
        #1;
        chk("fr_valid", inst_valid_o, 0);
        chk("fr_no_dead", inst_o == 32'hdead_beef, 0);
        chk("fr_idle_noce", stallreq_o, 0);
        adv();
        fetch(32'h8000_0200, 0, 1, 32'h0000_0021, 1, 1'b0);

        // flush coinciding with data_ok in WAIT
        ce_i = 1'b1; pc_i = 32'h0040_0000;
        adv();
        addr_ok_i = 1'b1;
        adv();
        addr_ok_i = 1'b0; data_ok_i = 1'b1; flush_i = 1'b1; rdata_i = 32'h1234_5678;
        #1; chk("fw_stallreq", stallreq_o, 1);
        adv();
        data_ok_i = 1'b0; flush_i = 1'b0; ce_i = 1'b0;
        #1;
        chk("fw_valid", inst_valid_o, 0);
        chk("fw_inst", inst_o, 32'h0000_0021);
        adv();

        // flush and stall together in DONE: flush wins
        fetch(32'h0040_0004, 0, 1, 32'h0c10_0000, 2, 1'b1);

        // misaligned fetch
        ce_i = 1'b1; pc_i = 32'hbfc0_0002;
        #1; chk("mis_stallreq", stallreq_o, 1);
        adv();
        ce_i = 1'b0; stall_i = 1'b1;
        #1;
        chk("mis_req", req_o, 0);
        chk("mis_adel", adel_o, 1);
        chk("mis_inst", inst_o, 0);
        chk("mis_valid", inst_valid_o, 1);
        chk("mis_stallreq_done", stallreq_o, 0);
        adv();
        stall_i = 1'b0;
        #1; chk("mis_hold_adel", adel_o, 1);
        adv();
        #1;
        chk("mis_clr_adel", adel_o, 0);
        chk("mis_clr_valid", inst_valid_o, 0);

        fetch(32'hbfc0_0100, 0, 1, 32'hcafe_0001, 0, 1'b0);
        // reset while in WAIT; later stale data_ok must be ignored
        ce_i = 1'b1; pc_i = 32'hbfc0_0104;
        adv();
        addr_ok_i = 1'b1;
        adv();
        addr_ok_i = 1'b0; rst = 1'b1;
        #1; chk("rw_stallreq", stallreq_o, 0);
        adv();
        rst = 1'b0; ce_i = 1'b0; data_ok_i = 1'b1; rdata_i = 32'hbad0_bad0;
        #1;
        chk("rw_req", req_o, 0);
        chk("rw_addr", addr_o, 0);
        chk("rw_inst", inst_o, 0);
        chk("rw_valid", inst_valid_o, 0);
        chk("rw_stallreq2", stallreq_o, 0);
        adv();
        data_ok_i = 1'b0;
        #1;
        chk("rw_stale_valid", inst_valid_o, 0);
        chk("rw_stale_inst", inst_o, 0);
        adv();

        // randomized fetches
        for (int k = 0; k < 24; k++) begin
            pc = $urandom & 32'hffff_fffc;
            if ($urandom_range(1, 0) == 1) pc[31:30] = 2'b10;
            fetch(pc, $urandom_range(3, 0), $urandom_range(3, 1), $urandom,
                  $urandom_range(2, 0), ($urandom_range(3, 0) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
